// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding for the restoring divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift, subtract, select)
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_dvs,
  output logic [N:0]   o_rem,
  output logic         o_qbit
);
  logic [N+1:0] w_sh;
  logic [N+1:0] w_diff;
  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh - {2'b00, i_dvs};
  assign o_qbit = ~w_diff[N+1];
  assign o_rem  = o_qbit ? w_diff[N:0] : w_sh[N:0];
endmodule

// File: rtl/sub_divider_ctrl.sv
// sub_divider_ctrl: N-cycle restoring unsigned divider; DIV_ZERO_CHECK_EN enables 1-cycle divide-by-zero handling
module sub_divider_ctrl
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N) + 1;
  state_t        r_state;
  logic [N:0]    r_rem;
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic [N:0]    w_rem;
  logic          w_qbit;
  div_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[N-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );
  // r_dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_dvd       <= dividend;
          r_dvs       <= divisor;
          r_rem       <= '0;
          r_cnt       <= '0;
          div_by_zero <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == '0) begin
            r_state     <= DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            r_state <= RUN;
            busy    <= 1'b1;
          end
`else
          r_state <= RUN;
          busy    <= 1'b1;
`endif
        end
        RUN: begin
          r_rem <= w_rem;
          r_dvd <= {r_dvd[N-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {r_dvd[N-2:0], w_qbit};
            remainder <= w_rem[N-1:0];
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_divider_ctrl.sv
// tb_sub_divider_ctrl: randomized and directed checks of sub_divider_ctrl against an arithmetic model
module tb_sub_divider_ctrl;
  localparam int N = 4;
  localparam int ONES = (1 << N) - 1;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  int n_cmp = 0;
  int n_bad = 0;
  int hold_q = 0;
  int hold_r = 0;
  sub_divider_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  // called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle
  task automatic do_div(input int a, input int b, input bit poke);
    int cyc = 0;
    int nbusy = 0;
    int eq, er, lat;
    bit fast;
`ifdef DIV_ZERO_CHECK_EN
    fast = (b == 0);
`else
    fast = 1'b0;
`endif
    eq  = (b != 0) ? a / b : ONES;
    er  = (b != 0) ? a % b : a;
    lat = fast ? 1 : N + 1;
    start = 1'b1;
    dividend = N'(a);
    divisor = N'(b);
    do begin
      @(negedge clk);
      cyc++;
      start    = poke;
      dividend = poke ? N'(9) : N'($urandom);
      divisor  = poke ? N'(2) : N'($urandom);
      if (busy) nbusy++;
      chk("busy_and_done", 32'(busy & done), 0);
      if (!done) begin
        chk("hold_quotient", 32'(quotient), hold_q);
        chk("hold_remainder", 32'(remainder), hold_r);
      end
    end while (!done && cyc < 3 * N + 4);
    start = 1'b0;
    chk("latency", cyc, lat);
    chk("busy_cycles", nbusy, fast ? 0 : N);
    chk("quotient", 32'(quotient), eq);
    chk("remainder", 32'(remainder), er);
    chk("div_by_zero", 32'(div_by_zero), 32'(fast));
    if (b != 0) begin
      chk("identity", int'(quotient) * b + int'(remainder), a);
      chk("rem_lt_div", 32'(int'(remainder) < b), 1);
    end
    hold_q = eq;
    hold_r = er;
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 0);
    chk("idle_not_busy", 32'(busy), 0);
  endtask
  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_quotient"}, 32'(quotient), 0);
    chk({tag, "_remainder"}, 32'(remainder), 0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    do_div(13, 3, 1'b0);
    do_div(15, 1, 1'b0);
    do_div(2, 7, 1'b0);
    do_div(13, 3, 1'b1);
    do_div(6, 0, 1'b0);
    do_div(11, 4, 1'b0);
    start = 1'b1;
    dividend = 4'd13;
    divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("abort");
    hold_q = 0;
    hold_r = 0;
    repeat (N + 2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    rst = 1'b1;
    start = 1'b1;
    dividend = 4'd9;
    divisor = 4'd2;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_priority_busy", 32'(busy), 0);
    @(negedge clk);
    chk("rst_priority_idle", 32'(busy), 0);
    for (int a = 0; a <= ONES; a++)
      for (int b = 1; b <= ONES; b++)
        do_div(a, b, 1'b0);
    repeat (60) do_div(int'($urandom_range(ONES, 0)), int'($urandom_range(ONES, 0)), 1'($urandom_range(1, 0)));
    do_div(0, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sub_divider_ctrl.md
SUB_DIVIDER_CTRL -- requirements
Module: sub_divider_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 SHALL have port dividend, input, N bits: unsigned dividend, sampled with start.
REQ-006 SHALL have port divisor, input, N bits: unsigned divisor, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high while an iteration is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 SHALL have port quotient, output, N bits: unsigned quotient.
REQ-010 SHALL have port remainder, output, N bits: unsigned remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit: divisor-zero flag (see Configuration).

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, a start sampled high SHALL capture dividend and divisor, clear the partial remainder (N+1 bits) and the iteration counter, and enter RUN.
REQ-014 In RUN, each cycle SHALL perform one restoring step: shift the partial remainder left, insert the next dividend bit (MSB first), and subtract the zero-extended divisor at N+1 bits.
REQ-015 When the step produces no borrow, it SHALL keep the difference and shift 1 into the quotient; on borrow, it SHALL keep the shifted remainder and shift 0 into the quotient.
REQ-016 RUN SHALL last exactly N cycles, counted by a counter of width clog2(N)+1, then transition to DONE.
REQ-017 In DONE, done SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE on the next cycle.
REQ-018 Latency SHALL be N+1 cycles from the edge that samples start to the cycle in which done is high.
REQ-019 busy SHALL be high in RUN only; done SHALL be high in DONE only; busy and done SHALL never be high together.
REQ-020 start SHALL be ignored in RUN and DONE; operands SHALL be ignored when start is low.
REQ-021 quotient and remainder SHALL update only when the result is committed, and SHALL hold until the next committed result.
REQ-022 A start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operation).
REQ-023 The result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for all divisor != 0.

Reset
REQ-024 While rst is high at a clock edge, the FSM SHALL go to IDLE, and busy, done, div_by_zero, quotient, remainder and all internal registers SHALL go to 0.
REQ-025 rst asserted mid-RUN SHALL abort the operation, with no done pulse for that operation.
REQ-026 rst SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro DIV_ZERO_CHECK_EN SHALL control divisor-zero detection.
REQ-028 With DIV_ZERO_CHECK_EN defined, a start with divisor == 0 SHALL go directly from IDLE to DONE, giving a latency of 1 cycle.
REQ-029 In that case the block SHALL set quotient = all ones, remainder = dividend and div_by_zero = 1; div_by_zero SHALL clear on the next accepted start.
REQ-030 Without DIV_ZERO_CHECK_EN, div_by_zero SHALL be constant 0, and divisor == 0 SHALL run the full N cycles, naturally yielding quotient = all ones and remainder = dividend.

Structure
REQ-031 The FSM state enum (IDLE/RUN/DONE) SHALL be defined in the shared package div_pkg.
REQ-032 One sub-module SHALL be used: div_step, a combinational N+1-bit shift/subtract/select stage (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit).
REQ-033 The controller SHALL hold all registers; div_step SHALL contain none.

Verification
REQ-034 Scenario: N=4, start with dividend=13, divisor=3 -> done 5 cycles later, quotient=4, remainder=1, busy high for 4 cycles.
REQ-035 Scenario: N=4, 15/1 then 2/7 back-to-back -> quotient=15, remainder=0; then quotient=0, remainder=2; each done is a single-cycle pulse.
REQ-036 Scenario: start re-asserted with 9/2 during RUN of 13/3 -> ignored; result quotient=4, remainder=1.
REQ-037 Scenario: rst pulsed in the 2nd RUN cycle -> next cycle state IDLE, all outputs 0, no done.
REQ-038 Scenario: N=4, 6/0 with DIV_ZERO_CHECK_EN -> done 1 cycle later, div_by_zero=1, quotient=15, remainder=6.
REQ-039 Scenario: N=4, 6/0 without DIV_ZERO_CHECK_EN -> done 5 cycles later, quotient=15, remainder=6, div_by_zero=0.
REQ-040 Scenario: exhaustive N=4 self-check of all dividend/divisor pairs with divisor != 0 -> REQ-023 holds for every pair.
